// File: rtl/operand_commit_pkg.sv
// rtl/operand_commit_pkg.sv - shared state encoding and descriptor field widths
// Purpose: FSM state type and the widths of the write-descriptor fields
//          shared by operand_commit and commit_dest_mux.
// Ports:   none (package).

package operand_commit_pkg;

  // Commit FSM: idle, first write (dst0), second write (dst1, swap only).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR0  = 2'd1,
    ST_WR1  = 2'd2
  } state_t;

  // Destination descriptor field widths.
  localparam int ADDR_W     = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 3;

endpackage

// File: rtl/commit_dest_mux.sv
// rtl/commit_dest_mux.sv - selects the dst0/dst1 write descriptor by FSM state
// Purpose: drives the shared write-port descriptor from the latched dst0
//          fields in WR0, the latched dst1 fields in WR1, and all-zero in IDLE.
// Ports:   state            - registered FSM state
//          d0_* / d1_*      - latched destination fields and data
//          wr_is_mem, wr_reg, wr_addr, wr_data - selected descriptor

module commit_dest_mux
  import operand_commit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  state_t              state,
  input  logic                d0_is_mem,
  input  logic [REG_W-1:0]    d0_reg,
  input  logic [ADDR_W-1:0]   d0_addr,
  input  logic [DATA_W-1:0]   d0_data,
  input  logic                d1_is_mem,
  input  logic [REG_W-1:0]    d1_reg,
  input  logic [ADDR_W-1:0]   d1_addr,
  input  logic [DATA_W-1:0]   d1_data,
  output logic                wr_is_mem,
  output logic [REG_W-1:0]    wr_reg,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data
);

  always_comb begin
    wr_is_mem = 1'b0;
    wr_reg    = '0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state)
      ST_WR0: begin
        wr_is_mem = d0_is_mem;
        wr_reg    = d0_reg;
        wr_addr   = d0_addr;
        wr_data   = d0_data;
      end
      ST_WR1: begin
        wr_is_mem = d1_is_mem;
        wr_reg    = d1_reg;
        wr_addr   = d1_addr;
        wr_data   = d1_data;
      end
      default: begin
        wr_is_mem = 1'b0;
        wr_reg    = '0;
        wr_addr   = '0;
        wr_data   = '0;
      end
    endcase
  end

endmodule

// File: rtl/operand_commit.sv
// rtl/operand_commit.sv - commits a move/swap execute result through one write port
// Purpose: accepts a move (one write) or swap (two writes) result, latches it,
//          and serialises the writes over a shared valid/ready write port.
//          A swap whose destinations are both memory is dropped with an err pulse.
// Ports:   clk, rst (async, active-high)
//          in_valid/in_ready, in_swap, opnd0_w, opnd1_w, dst{0,1}_is_mem/_reg/_addr
//          wr_valid/wr_ready, wr_is_mem, wr_reg, wr_addr, wr_data
//          done (commit complete pulse), err (illegal result pulse)

module operand_commit
  import operand_commit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_swap,
  input  logic [DATA_W-1:0]   opnd0_w,
  input  logic [DATA_W-1:0]   opnd1_w,
  input  logic                dst0_is_mem,
  input  logic                dst1_is_mem,
  input  logic [REG_W-1:0]    dst0_reg,
  input  logic [REG_W-1:0]    dst1_reg,
  input  logic [ADDR_W-1:0]   dst0_addr,
  input  logic [ADDR_W-1:0]   dst1_addr,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic                wr_is_mem,
  output logic [REG_W-1:0]    wr_reg,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                done,
  output logic                err
);

  state_t state, state_nxt;
  logic   accept;
  logic   illegal;
  logic   done_nxt;
  logic   err_nxt;

  logic                l_swap;
  logic                l_d0_mem, l_d1_mem;
  logic [REG_W-1:0]    l_d0_reg, l_d1_reg;
  logic [ADDR_W-1:0]   l_d0_addr, l_d1_addr;
  logic [DATA_W-1:0]   l_op0, l_op1;

  // in_ready is held low while reset is asserted, not just once state clears.
  assign in_ready = (state == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  // Memory-to-memory swap cannot be committed; it is dropped at acceptance.
  assign illegal  = in_swap && dst0_is_mem && dst1_is_mem;
  assign wr_valid = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (illegal) err_nxt   = 1'b1;
          else         state_nxt = ST_WR0;
        end
      end
      ST_WR0: begin
        if (wr_ready) begin
          if (l_swap) begin
            state_nxt = ST_WR1;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_WR1: begin
        if (wr_ready) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_swap    <= 1'b0;
      l_d0_mem  <= 1'b0;
      l_d1_mem  <= 1'b0;
      l_d0_reg  <= '0;
      l_d1_reg  <= '0;
      l_d0_addr <= '0;
      l_d1_addr <= '0;
      l_op0     <= '0;
      l_op1     <= '0;
    end else if (accept) begin
      l_swap    <= in_swap;
      l_d0_mem  <= dst0_is_mem;
      l_d1_mem  <= dst1_is_mem;
      l_d0_reg  <= dst0_reg;
      l_d1_reg  <= dst1_reg;
      l_d0_addr <= dst0_addr;
      l_d1_addr <= dst1_addr;
      l_op0     <= opnd0_w;
      l_op1     <= opnd1_w;
    end
  end

  commit_dest_mux #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_dest_mux (
    .state     (state),
    .d0_is_mem (l_d0_mem),
    .d0_reg    (l_d0_reg),
    .d0_addr   (l_d0_addr),
    .d0_data   (l_op0),
    .d1_is_mem (l_d1_mem),
    .d1_reg    (l_d1_reg),
    .d1_addr   (l_d1_addr),
    .d1_data   (l_op1),
    .wr_is_mem (wr_is_mem),
    .wr_reg    (wr_reg),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

endmodule

// File: tb/tb_operand_commit.sv
// tb/tb_operand_commit.sv - directed table-driven bench for operand_commit

module tb_operand_commit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_swap;
  logic [31:0] opnd0_w, opnd1_w;
  logic        dst0_is_mem, dst1_is_mem;
  logic [2:0]  dst0_reg, dst1_reg;
  logic [31:0] dst0_addr, dst1_addr;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_is_mem;
  logic [2:0]  wr_reg;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  operand_commit #(.DATA_W(32), .REG_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_swap     (in_swap),
    .opnd0_w     (opnd0_w),
    .opnd1_w     (opnd1_w),
    .dst0_is_mem (dst0_is_mem),
    .dst1_is_mem (dst1_is_mem),
    .dst0_reg    (dst0_reg),
    .dst1_reg    (dst1_reg),
    .dst0_addr   (dst0_addr),
    .dst1_addr   (dst1_addr),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_is_mem   (wr_is_mem),
    .wr_reg      (wr_reg),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        swap;
    logic        d0_mem;
    logic [2:0]  d0_reg;
    logic [31:0] d0_addr;
    logic [31:0] op0;
    logic        d1_mem;
    logic [2:0]  d1_reg;
    logic [31:0] d1_addr;
    logic [31:0] op1;
    int          stall0;
    int          stall1;
    logic        exp_err;
    int          exp_nw;
    logic [67:0] exp_w0;
    logic [67:0] exp_w1;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(logic sw, logic m0, logic [2:0] r0, logic [31:0] a0, logic [31:0] o0,
                              logic m1, logic [2:0] r1, logic [31:0] a1, logic [31:0] o1,
                              int s0, int s1, logic e, int nw, logic [67:0] w0, logic [67:0] w1, int lat);
    vec_t v;
    v.swap = sw; v.d0_mem = m0; v.d0_reg = r0; v.d0_addr = a0; v.op0 = o0;
    v.d1_mem = m1; v.d1_reg = r1; v.d1_addr = a1; v.op1 = o1;
    v.stall0 = s0; v.stall1 = s1; v.exp_err = e; v.exp_nw = nw;
    v.exp_w0 = w0; v.exp_w1 = w1; v.exp_lat = lat;
    return v;
  endfunction

  function automatic logic [67:0] cur_desc();
    return {wr_is_mem, wr_reg, wr_addr, wr_data};
  endfunction

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_idle_inputs();
    in_valid = 0; in_swap = 0; opnd0_w = 0; opnd1_w = 0;
    dst0_is_mem = 0; dst1_is_mem = 0; dst0_reg = 0; dst1_reg = 0;
    dst0_addr = 0; dst1_addr = 0;
  endtask

  // Offer one result, then follow it to done/err, checking every write cycle.
  task automatic run_vec(input string tag, input vec_t v);
    int cyc, nw, vcyc, s0, s1, lat;
    logic got_end, saw_done, saw_err;
    check({tag, " in_ready before"}, 68'(in_ready), 68'd1);
    in_swap = v.swap; opnd0_w = v.op0; opnd1_w = v.op1;
    dst0_is_mem = v.d0_mem; dst0_reg = v.d0_reg; dst0_addr = v.d0_addr;
    dst1_is_mem = v.d1_mem; dst1_reg = v.d1_reg; dst1_addr = v.d1_addr;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    in_swap = ~v.swap; opnd0_w = ~v.op0; opnd1_w = ~v.op1;
    dst0_reg = ~v.d0_reg; dst0_addr = ~v.d0_addr; dst1_addr = ~v.d1_addr;
    cyc = 1; nw = 0; vcyc = 0; s0 = v.stall0; s1 = v.stall1; lat = 0;
    got_end = 0; saw_done = 0; saw_err = 0;
    while (!got_end && cyc < 40) begin
      wr_ready = ((nw == 0 && s0 > 0) || (nw == 1 && s1 > 0)) ? 1'b0 : 1'b1;
      #1;
      if (done || err) begin
        got_end = 1; lat = cyc; saw_done = done; saw_err = err;
        check({tag, " idle wr_valid"}, 68'(wr_valid), 68'd0);
        check({tag, " idle desc"}, cur_desc(), 68'd0);
        check({tag, " in_ready at end"}, 68'(in_ready), 68'd1);
      end else if (wr_valid) begin
        vcyc++;
        check($sformatf("%s write%0d desc", tag, nw), cur_desc(), (nw == 0) ? v.exp_w0 : v.exp_w1);
        if (wr_ready) nw++;
        else if (nw == 0) s0--;
        else s1--;
      end
      if (!got_end) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, " finished"}, 68'(got_end), 68'd1);
    check({tag, " handshakes"}, 68'(nw), 68'(v.exp_nw));
    check({tag, " valid cycles"}, 68'(vcyc), 68'(v.exp_nw + v.stall0 + v.stall1));
    check({tag, " latency"}, 68'(lat), 68'(v.exp_lat));
    check({tag, " err"}, 68'(saw_err), 68'(v.exp_err));
    check({tag, " done"}, 68'(saw_done), 68'(!v.exp_err));
    @(posedge clk); #1;
    check({tag, " pulse ends"}, 68'({done, err}), 68'd0);
    drive_idle_inputs();
  endtask

  initial begin
    vecs[0] = mk(0, 0, 3'd3, 32'h0, 32'hDEADBEEF, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 1,
                 {1'b0, 3'd3, 32'h0, 32'hDEADBEEF}, 68'd0, 2);
    vecs[1] = mk(1, 0, 3'd1, 32'h0, 32'h11, 1, 3'd0, 32'h1000, 32'h22, 0, 0, 0, 2,
                 {1'b0, 3'd1, 32'h0, 32'h11}, {1'b1, 3'd0, 32'h1000, 32'h22}, 3);
    vecs[2] = mk(1, 1, 3'd0, 32'h2000, 32'hCAFE0001, 0, 3'd5, 32'h0, 32'h12345678, 0, 4, 0, 2,
                 {1'b1, 3'd0, 32'h2000, 32'hCAFE0001}, {1'b0, 3'd5, 32'h0, 32'h12345678}, 7);
    vecs[3] = mk(1, 1, 3'd2, 32'h3000, 32'h33, 1, 3'd4, 32'h4000, 32'h44, 0, 0, 1, 0,
                 68'd0, 68'd0, 1);
    vecs[4] = mk(1, 0, 3'd2, 32'h0, 32'hA, 0, 3'd2, 32'h0, 32'hB, 0, 0, 0, 2,
                 {1'b0, 3'd2, 32'h0, 32'hA}, {1'b0, 3'd2, 32'h0, 32'hB}, 3);
    vecs[5] = mk(0, 1, 3'd0, 32'hFFFFFFFC, 32'hFFFFFFFF, 0, 3'd0, 32'h0, 32'h0, 3, 0, 0, 1,
                 {1'b1, 3'd0, 32'hFFFFFFFC, 32'hFFFFFFFF}, 68'd0, 5);
    vecs[6] = mk(0, 1, 3'd7, 32'h40, 32'h5, 1, 3'd1, 32'h80, 32'h6, 0, 0, 0, 1,
                 {1'b1, 3'd7, 32'h40, 32'h5}, 68'd0, 2);

    // Reset state.
    drive_idle_inputs();
    wr_ready = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset wr_valid", 68'(wr_valid), 68'd0);
    check("reset in_ready", 68'(in_ready), 68'd0);
    check("reset done/err", 68'({done, err}), 68'd0);
    check("reset desc", cur_desc(), 68'd0);
    rst = 0;
    #1;
    check("post-reset in_ready", 68'(in_ready), 68'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset asserted while a swap waits in WR1.
    begin
      in_swap = 1; dst0_is_mem = 0; dst0_reg = 3'd4; opnd0_w = 32'h1;
      dst1_is_mem = 0; dst1_reg = 3'd6; opnd1_w = 32'h2;
      wr_ready = 1; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk); #1;
      wr_ready = 0;
      #1;
      check("midrst wr1 desc", cur_desc(), {1'b0, 3'd6, 32'h0, 32'h2});
      #2 rst = 1;
      #1;
      check("midrst wr_valid drop", 68'(wr_valid), 68'd0);
      check("midrst in_ready low", 68'(in_ready), 68'd0);
      check("midrst desc zero", cur_desc(), 68'd0);
      @(posedge clk); #1;
      check("midrst no done", 68'(done), 68'd0);
      rst = 0;
      wr_ready = 1;
      #1;
      check("midrst in_ready after", 68'(in_ready), 68'd1);
      @(posedge clk); #1;
      check("midrst not replayed", 68'({wr_valid, done}), 68'd0);
      drive_idle_inputs();
      run_vec("after_rst", vecs[0]);
    end

    // 100 back-to-back moves with in_valid held high.
    begin
      logic [67:0] exp_q[$];
      logic [67:0] exp_d;
      int acc, wcount, dcount, cyc;
      logic accepting;
      acc = 0; wcount = 0; dcount = 0; cyc = 0;
      wr_ready = 1;
      in_swap = 0; dst1_is_mem = 1; dst1_reg = 3'd7; dst1_addr = 32'hFFFF0000; opnd1_w = 32'hFFFFFFFF;
      dst0_is_mem = 0; dst0_reg = 0; dst0_addr = 0; opnd0_w = 32'h5A5A0000;
      in_valid = 1;
      while (dcount < 100 && cyc < 1000) begin
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            check("b2b unexpected write", cur_desc(), 68'd0);
          end else begin
            exp_d = exp_q.pop_front();
            check($sformatf("b2b write%0d", wcount), cur_desc(), exp_d);
          end
          wcount++;
        end
        if (done) dcount++;
        accepting = in_valid && in_ready;
        if (accepting) begin
          exp_q.push_back({dst0_is_mem, dst0_reg, dst0_addr, opnd0_w});
          acc++;
        end
        @(posedge clk); #1;
        cyc++;
        if (accepting) begin
          if (acc == 100) begin
            in_valid = 0;
          end else begin
            dst0_is_mem = acc[0];
            dst0_reg    = acc[2:0];
            dst0_addr   = 32'(acc) * 32'd4;
            opnd0_w     = (32'(acc) * 32'h01010101) ^ 32'h5A5A0000;
          end
        end
      end
      check("b2b accepted", 68'(acc), 68'd100);
      check("b2b writes", 68'(wcount), 68'd100);
      check("b2b dones", 68'(dcount), 68'd100);
      check("b2b leftover", 68'(exp_q.size()), 68'd0);
      drive_idle_inputs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
